delaybuffer_prog: RTL and testbench

Runtime-programmable ready/valid delay line for the tuner sample path. Each accepted sample produces one output sample equal to the input accepted D transactions earlier, where D is loaded at run time in the range 0..max_delay_p. Outputs are zero until D samples have been accepted since reset or since the last delay reload. It replaces fixed-delay buffers wherever the lag must be retuned without a rebuild, such as autocorrelation lag sweeps.

---
 rtl/delaybuffer_prog_if.sv | 29 ++
 rtl/delaybuffer_prog.sv | 107 ++++++++++
 tb/tb_delaybuffer_prog.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/delaybuffer_prog_if.sv
// Sample/config bundle for the programmable delay line.
// The slave modport is the delay line's own view; master is the driver's view.
interface delaybuffer_prog_if #(
    parameter int width_p     = 8,
    parameter int max_delay_p = 8
);
    localparam int dw_lp = $clog2(max_delay_p + 1);

    logic               cfg_valid_i;
    logic [dw_lp-1:0]   cfg_delay_i;
    logic [width_p-1:0] data_i;
    logic               valid_i;
    logic               ready_o;
    logic               valid_o;
    logic [width_p-1:0] data_o;
    logic               ready_i;
    logic               primed_o;
    logic [dw_lp-1:0]   delay_o;

    modport master (
        output cfg_valid_i, cfg_delay_i, data_i, valid_i, ready_i,
        input  ready_o, valid_o, data_o, primed_o, delay_o
    );

    modport slave (
        input  cfg_valid_i, cfg_delay_i, data_i, valid_i, ready_i,
        output ready_o, valid_o, data_o, primed_o, delay_o
    );
endinterface

// File: rtl/delaybuffer_prog.sv
// Run-time programmable ready/valid delay line. Each accepted sample returns
// the sample accepted D transactions earlier (zero until D samples have been
// seen since reset or reload). D = 0 passes the input straight through via a
// registered bypass instead of the ring RAM.
module delaybuffer_prog #(
    parameter int width_p       = 8,
    parameter int max_delay_p   = 8,
    parameter int reset_delay_p = max_delay_p
) (
    input  logic               clk_i,
    input  logic               reset_i,
    delaybuffer_prog_if.slave  bus
);
    localparam int depth_lp = max_delay_p + 1;
    localparam int dw_lp    = $clog2(max_delay_p + 1);

    // Ring storage, one slot more than the largest delay so the read slot
    // never collides with the slot being written.
    logic [width_p-1:0] r_ram [0:max_delay_p];
    logic [width_p-1:0] r_ram_q;

    logic [dw_lp-1:0]   r_wp;
    logic [dw_lp-1:0]   r_fill;
    logic [dw_lp-1:0]   r_delay;
    logic               r_primed;
    logic               r_valid;
    logic               r_zero;
    logic               r_bypass;
    logic [width_p-1:0] r_byp_data;

    logic               w_ready;
    logic               w_acc;
    logic [dw_lp-1:0]   w_cfg_delay;
    logic [dw_lp-1:0]   w_wp_inc;
    logic [dw_lp:0]     w_rd_sum;
    logic [dw_lp-1:0]   w_rd_addr;
    logic [dw_lp-1:0]   w_fill_inc;

    // A reload cycle never accepts, so cfg and accept are mutually exclusive.
    assign w_ready = (~r_valid | bus.ready_i) & ~bus.cfg_valid_i;
    assign w_acc   = bus.valid_i & w_ready;

    // Oversized delay requests saturate at the ring capacity.
    assign w_cfg_delay = (bus.cfg_delay_i > dw_lp'(max_delay_p)) ?
                         dw_lp'(max_delay_p) : bus.cfg_delay_i;

    assign w_wp_inc = (r_wp == dw_lp'(max_delay_p)) ? '0 : r_wp + 1'b1;

    // (wp - D) mod depth without underflow: add the depth in a wider sum
    // only when wp < D; the result then always lies below depth.
    assign w_rd_sum  = {1'b0, r_wp} + (dw_lp + 1)'(depth_lp) - {1'b0, r_delay};
    assign w_rd_addr = (r_wp >= r_delay) ? (r_wp - r_delay) : w_rd_sum[dw_lp-1:0];

    assign w_fill_inc = (r_fill < r_delay) ? r_fill + 1'b1 : r_fill;

    // RAM write of the incoming sample and synchronous read of the delayed one.
    always_ff @(posedge clk_i) begin
        if (w_acc) begin
            r_ram[r_wp] <= bus.data_i;
            r_ram_q     <= r_ram[w_rd_addr];
        end
    end

    // Control state, output handshake and output source selection.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wp       <= '0;
            r_fill     <= '0;
            r_delay    <= dw_lp'(reset_delay_p);
            r_primed   <= 1'b0;
            r_valid    <= 1'b0;
            r_zero     <= 1'b1;
            r_bypass   <= 1'b0;
            r_byp_data <= '0;
        end else begin
            if (bus.cfg_valid_i) begin
                r_delay  <= w_cfg_delay;
                r_fill   <= '0;
                r_primed <= (w_cfg_delay == '0);
            end else if (w_acc) begin
                r_wp     <= w_wp_inc;
                r_fill   <= w_fill_inc;
                r_primed <= (w_fill_inc == r_delay);
            end

            if (~r_valid | bus.ready_i) begin
                r_valid <= w_acc;
            end

            // Source selection is captured with the sample so a stalled
            // output stays stable even if a reload lands meanwhile.
            if (w_acc) begin
                r_zero     <= (r_fill < r_delay);
                r_bypass   <= (r_delay == '0);
                r_byp_data <= bus.data_i;
            end
        end
    end

    assign bus.ready_o  = w_ready;
    assign bus.valid_o  = r_valid;
    assign bus.data_o   = r_zero   ? '0 :
                          r_bypass ? r_byp_data : r_ram_q;
    assign bus.primed_o = r_primed;
    assign bus.delay_o  = r_delay;

endmodule

// File: tb/tb_delaybuffer_prog.sv
// Directed bench for delaybuffer_prog (width 8, max delay 8).
module tb_delaybuffer_prog;
    logic clk_i;
    logic reset_i;

    delaybuffer_prog_if #(.width_p(8), .max_delay_p(8)) bus ();

    delaybuffer_prog #(
        .width_p       (8),
        .max_delay_p   (8),
        .reset_delay_p (8)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // random-backpressure reference model state
    int         n;
    int         cyc;
    logic       m_valid;
    logic [7:0] m_data;
    logic [7:0] hist [0:39];
    logic       rdy;
    logic       vin;
    logic       mr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i         = 1'b1;
        bus.cfg_valid_i = 1'b0;
        bus.cfg_delay_i = '0;
        bus.data_i      = '0;
        bus.valid_i     = 1'b0;
        bus.ready_i     = 1'b1;

        // reset state
        #2;
        chk("rst_valid",  32'(bus.valid_o),  32'd0);
        chk("rst_data",   32'(bus.data_o),   32'd0);
        chk("rst_primed", 32'(bus.primed_o), 32'd0);
        chk("rst_delay",  32'(bus.delay_o),  32'd8);
        tick();
        reset_i = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.ready_o), 32'd1);

        // reset delay of 8: stream 1..20
        for (int i = 1; i <= 20; i++) begin
            bus.data_i  = 8'(i);
            bus.valid_i = 1'b1;
            #1;
            chk("a_ready", 32'(bus.ready_o), 32'd1);
            tick();
            chk("a_valid",  32'(bus.valid_o),  32'd1);
            chk("a_data",   32'(bus.data_o),   (i <= 8) ? 32'd0 : 32'(i - 8));
            chk("a_primed", 32'(bus.primed_o), (i >= 8) ? 32'd1 : 32'd0);
            $display("A in=%0d out=%0d primed=%0b", i, bus.data_o, bus.primed_o);
        end

        // reload D=3
        bus.valid_i     = 1'b0;
        bus.cfg_valid_i = 1'b1;
        bus.cfg_delay_i = 4'd3;
        #1;
        chk("b_cfg_ready", 32'(bus.ready_o), 32'd0);
        tick();
        bus.cfg_valid_i = 1'b0;
        chk("b_delay",  32'(bus.delay_o),  32'd3);
        chk("b_primed", 32'(bus.primed_o), 32'd0);
        chk("b_valid",  32'(bus.valid_o),  32'd0);

        for (int k = 0; k < 6; k++) begin
            bus.data_i  = 8'(11 + k);
            bus.valid_i = 1'b1;
            #1;
            tick();
            chk("b_data",   32'(bus.data_o),   (k < 3) ? 32'd0 : 32'(11 + k - 3));
            chk("b_primed", 32'(bus.primed_o), (k >= 2) ? 32'd1 : 32'd0);
            chk("b_delay",  32'(bus.delay_o),  32'd3);
            $display("B in=%0d out=%0d primed=%0b", 11 + k, bus.data_o, bus.primed_o);
        end

        // pass-through D=0
        bus.valid_i     = 1'b0;
        bus.cfg_valid_i = 1'b1;
        bus.cfg_delay_i = 4'd0;
        #1;
        tick();
        bus.cfg_valid_i = 1'b0;
        chk("c_delay",  32'(bus.delay_o),  32'd0);
        chk("c_primed", 32'(bus.primed_o), 32'd1);
        for (int k = 5; k <= 7; k++) begin
            bus.data_i  = 8'(k);
            bus.valid_i = 1'b1;
            #1;
            tick();
            chk("c_valid", 32'(bus.valid_o), 32'd1);
            chk("c_data",  32'(bus.data_o),  32'(k));
            $display("C in=%0d out=%0d", k, bus.data_o);
        end

        // clamp + reload while output stalled (data_o holds 7)
        bus.ready_i     = 1'b0;
        bus.valid_i     = 1'b1;
        bus.data_i      = 8'h55;
        bus.cfg_valid_i = 1'b1;
        bus.cfg_delay_i = 4'd15;
        #1;
        chk("d_cfg_ready", 32'(bus.ready_o), 32'd0);
        tick();
        bus.cfg_valid_i = 1'b0;
        chk("d_delay",  32'(bus.delay_o),  32'd8);
        chk("d_valid",  32'(bus.valid_o),  32'd1);
        chk("d_data",   32'(bus.data_o),   32'd7);
        chk("d_primed", 32'(bus.primed_o), 32'd0);
        #1;
        chk("d_stall_ready", 32'(bus.ready_o), 32'd0);
        tick();
        chk("d_stall_data",  32'(bus.data_o),  32'd7);
        chk("d_stall_valid", 32'(bus.valid_o), 32'd1);
        $display("D stalled out=%0d delay=%0d", bus.data_o, bus.delay_o);
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        #1;
        chk("d_release_ready", 32'(bus.ready_o), 32'd1);
        tick();
        chk("d_release_valid", 32'(bus.valid_o), 32'd0);

        // random backpressure at D=8, 40 samples
        n       = 0;
        cyc     = 0;
        m_valid = 1'b0;
        m_data  = 8'd0;
        while (n < 40 && cyc < 400) begin
            rdy         = ($urandom_range(0, 3) != 0);
            vin         = ($urandom_range(0, 4) != 0);
            bus.ready_i = rdy;
            bus.valid_i = vin;
            bus.data_i  = 8'(n * 37 + 11);
            #1;
            mr = !m_valid || rdy;
            chk("r_ready", 32'(bus.ready_o), 32'(mr));
            if (vin && mr) begin
                if (n < 8) m_data = 8'd0;
                else       m_data = hist[n - 8];
                hist[n] = bus.data_i;
                n++;
            end
            if (!m_valid || rdy) m_valid = vin && mr;
            tick();
            cyc++;
            chk("r_valid", 32'(bus.valid_o), 32'(m_valid));
            if (m_valid) chk("r_data", 32'(bus.data_o), 32'(m_data));
            $display("R cyc=%0d rdy=%0b vin=%0b valid_o=%0b data_o=%0h", cyc, rdy, vin, bus.valid_o, bus.data_o);
        end
        chk("r_count", 32'(n), 32'd40);
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        #1;
        tick();
        chk("r_drain_valid", 32'(bus.valid_o), 32'd0);

        // asynchronous reset with a pending output
        bus.ready_i = 1'b0;
        bus.valid_i = 1'b1;
        bus.data_i  = 8'hAA;
        #1;
        chk("e_ready", 32'(bus.ready_o), 32'd1);
        tick();
        bus.valid_i = 1'b0;
        chk("e_valid", 32'(bus.valid_o), 32'd1);
        chk("e_data",  32'(bus.data_o),  32'(hist[32]));
        #2;
        reset_i = 1'b1;
        #1;
        chk("e_rst_valid",  32'(bus.valid_o),  32'd0);
        chk("e_rst_data",   32'(bus.data_o),   32'd0);
        chk("e_rst_primed", 32'(bus.primed_o), 32'd0);
        chk("e_rst_delay",  32'(bus.delay_o),  32'd8);
        $display("E async reset valid_o=%0b data_o=%0h", bus.valid_o, bus.data_o);
        #1;
        reset_i     = 1'b0;
        bus.ready_i = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            bus.data_i  = 8'(i);
            bus.valid_i = 1'b1;
            #1;
            tick();
            chk("e_data",   32'(bus.data_o),   (i == 9) ? 32'd1 : 32'd0);
            chk("e_primed", 32'(bus.primed_o), (i >= 8) ? 32'd1 : 32'd0);
            $display("E in=%0d out=%0d primed=%0b", i, bus.data_o, bus.primed_o);
        end
        bus.valid_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
